// File: rtl/reg8b_pkg.sv
// Shared types and constants for the 8-bit parallel-in / serial-out shifter.
package reg8b_pkg;

  localparam int DATA_W      = 8;
  localparam int DEFAULT_DIV = 25_000_000;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit of a word that sits next to the serial output for the chosen order.
  function automatic logic serial_bit(input logic [DATA_W-1:0] word, input logic msb_first);
    return msb_first ? word[DATA_W-1] : word[0];
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Free-running modulo-DIV counter producing a one-cycle clock enable (no derived clock).
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Held low while cleared so an idle DIV=1 divider never fires.
  assign tick = at_last & ~clr;

endmodule

// File: rtl/reg8b_piso.sv
// 8-bit parallel-in serial-out shifter; each bit is held for DIV clk_50M cycles.
module reg8b_piso
  import reg8b_pkg::*;
#(
  parameter int DIV       = DEFAULT_DIV,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam logic MSB_SEL = (MSB_FIRST != 0);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [2:0]        bit_cnt_q;
  logic [2:0]        bit_cnt_d;
  logic              out_q;
  logic              out_d;
  logic              done_q;
  logic              done_d;
  logic              div_clr;
  logic              tick;
  logic              last_tick;
  logic              capture;

  // Divider only runs in SHIFT, so it always starts a word from zero.
  assign div_clr = (state_q != SHIFT);

  clk_en_div #(
    .DIV (DIV)
  ) u_div (
    .clk_50M (clk_50M),
    .reset   (reset),
    .clr     (div_clr),
    .tick    (tick)
  );

  assign capture   = (state_q == IDLE) && load;
  assign last_tick = tick && (bit_cnt_q == 3'd7);

  // State register
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)      state_d = SHIFT;
      SHIFT:   if (last_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == SHIFT);
    out  = out_q;
    done = done_q;
  end

  // Datapath next values; out is registered from the post-edge word.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (capture) begin
      shift_d   = data_in;
      bit_cnt_d = 3'd0;
    end else if (tick) begin
      shift_d   = MSB_SEL ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    out_d  = (state_d == SHIFT) ? serial_bit(shift_d, MSB_SEL) : 1'b0;
    done_d = last_tick;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt_q <= 3'd0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      out_q     <= out_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_reg8b_piso.sv
// Directed bench: three shifter instances (DIV=4 MSB/LSB first, DIV=1) driven in turn.
module tb_reg8b_piso;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_w [3];
  logic       out_w  [3];
  logic       busy_w [3];
  logic       done_w [3];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  reg8b_piso #(.DIV(4), .MSB_FIRST(1)) u_msb (
    .clk_50M (clk), .reset (reset), .data_in (data_in), .load (load_w[0]),
    .out (out_w[0]), .busy (busy_w[0]), .done (done_w[0])
  );

  reg8b_piso #(.DIV(4), .MSB_FIRST(0)) u_lsb (
    .clk_50M (clk), .reset (reset), .data_in (data_in), .load (load_w[1]),
    .out (out_w[1]), .busy (busy_w[1]), .done (done_w[1])
  );

  reg8b_piso #(.DIV(1), .MSB_FIRST(1)) u_div1 (
    .clk_50M (clk), .reset (reset), .data_in (data_in), .load (load_w[2]),
    .out (out_w[2]), .busy (busy_w[2]), .done (done_w[2])
  );

  // Advance one cycle; outputs are then looked at 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("%s_out", tag), out_w[k], 1'b0);
    chk($sformatf("%s_busy", tag), busy_w[k], 1'b0);
    chk($sformatf("%s_done", tag), done_w[k], 1'b0);
  endtask

  // Entered in the first SHIFT cycle; seq lists the expected serial bits left to right.
  // poke_a/poke_b are SHIFT cycle numbers (1-based) in which load=1 with 0xFF is applied.
  // Returns in the done cycle after checking it.
  task automatic run_word(input int k, input int div, input logic [7:0] seq, input string tag,
                          input int poke_a, input int poke_b);
    int n;
    n = 1;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < div; c++) begin
        chk($sformatf("%s_out_b%0d_c%0d", tag, b, c), out_w[k], seq[7-b]);
        chk($sformatf("%s_busy_c%0d", tag, n), busy_w[k], 1'b1);
        chk($sformatf("%s_nodone_c%0d", tag, n), done_w[k], 1'b0);
        if (n == poke_a || n == poke_b) begin
          data_in   = 8'hFF;
          load_w[k] = 1'b1;
        end
        cyc();
        load_w[k] = 1'b0;
        n++;
      end
    end
    chk($sformatf("%s_done", tag), done_w[k], 1'b1);
    chk($sformatf("%s_end_busy", tag), busy_w[k], 1'b0);
    chk($sformatf("%s_end_out", tag), out_w[k], 1'b0);
  endtask

  // Load a word in the current cycle; the next cycle is the first SHIFT cycle.
  task automatic start_word(input int k, input logic [7:0] word);
    data_in   = word;
    load_w[k] = 1'b1;
    cyc();
    load_w[k] = 1'b0;
    data_in   = 8'h00;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    data_in  = 8'h00;
    for (int k = 0; k < 3; k++) load_w[k] = 1'b0;

    cyc();
    cyc();
    for (int k = 0; k < 3; k++) chk_idle(k, $sformatf("reset_i%0d", k));
    reset = 1'b0;
    cyc();

    // 0xA5 MSB first: 1,0,1,0,0,1,0,1 held 4 cycles each, done in cycle 33.
    start_word(0, 8'hA5);
    run_word(0, 4, 8'b10100101, "a5_msb", -1, -1);
    cyc();
    chk_idle(0, "a5_msb_after");

    // 0xA5 LSB first gives the same (palindromic) stream; 0x01 LSB first gives 1 then 0s.
    start_word(1, 8'hA5);
    run_word(1, 4, 8'b10100101, "a5_lsb", -1, -1);
    cyc();
    start_word(1, 8'h01);
    run_word(1, 4, 8'b10000000, "01_lsb", -1, -1);
    cyc();
    chk_idle(1, "01_lsb_after");

    // 0x3C with load pokes at cycle 5 and at the final tick (cycle 32): both ignored.
    start_word(0, 8'h3C);
    run_word(0, 4, 8'b00111100, "3c_poke", 5, 32);
    cyc();
    chk_idle(0, "3c_no_second_word");
    cyc();
    chk_idle(0, "3c_still_idle");

    // 0xC3 then 0x81 loaded in the done cycle: second word starts straight after it.
    start_word(0, 8'hC3);
    run_word(0, 4, 8'b11000011, "c3_first", -1, -1);
    start_word(0, 8'h81);
    run_word(0, 4, 8'b10000001, "81_second", -1, -1);
    cyc();
    chk_idle(0, "81_after");

    // 0xFF aborted by reset asserted in cycle 10.
    start_word(0, 8'hFF);
    for (int n = 1; n < 10; n++) begin
      chk($sformatf("ff_out_c%0d", n), out_w[0], 1'b1);
      cyc();
    end
    chk("ff_out_c10", out_w[0], 1'b1);
    chk("ff_busy_c10", busy_w[0], 1'b1);
    reset = 1'b1;
    cyc();
    chk_idle(0, "ff_abort");
    // Load accepted in the first cycle after reset deasserts.
    reset = 1'b0;
    start_word(0, 8'h80);
    run_word(0, 4, 8'b10000000, "80_after_rst", -1, -1);
    cyc();

    // Reset wins over a simultaneous load.
    reset     = 1'b1;
    data_in   = 8'hFF;
    load_w[0] = 1'b1;
    cyc();
    reset     = 1'b0;
    load_w[0] = 1'b0;
    chk_idle(0, "rst_over_load");
    cyc();
    chk("rst_over_load_next_busy", busy_w[0], 1'b0);

    // DIV=1: 0x96 one bit per cycle, busy 8 cycles, done in cycle 9.
    start_word(2, 8'h96);
    run_word(2, 1, 8'b10010110, "96_div1", -1, -1);
    cyc();
    chk_idle(2, "96_div1_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
